pipe_hazard_chain: RTL and testbench
====================================

// Module: pipe_hazard_chain
// PURPOSE
//  Parametrised in-order pipeline backbone: STAGES register slots (S0 youngest .. S[STAGES-1] oldest) carrying
//  payload, dest address, WB flag and result. Generates per-source operand forwarding (youngest match wins),
//  load-use style stall requests with bubble insertion, global hold and partial flush of the young slots.
//  Replaces the hand-wired stage buffers, forward bus and load-use detection of the 5-stage core.
// PARAMETERS
//  STAGES    4   number of pipeline slots (>=2)
//  PAYLOAD_W 64  opaque per-slot payload width (control/instruction bits)
//  DATA_W    16  result / operand width
//  REG_AW    3   register address width
//  NUM_SRC   2   source operands checked per issue
//  FLUSH_N   2   flush invalidates slots S0..S[FLUSH_N-1] (1<=FLUSH_N<=STAGES)
// PORTS
//  Clk          in   1                  clock, all state updates on rising edge
//  Rst          in   1                  synchronous active-high reset
//  in_valid     in   1                  issue candidate valid
//  in_payload   in   PAYLOAD_W          issue payload
//  in_wb        in   1                  candidate writes a register
//  in_dst       in   REG_AW             candidate dest address
//  in_result    in   DATA_W             early result (e.g. immediate)
//  in_res_rdy   in   1                  in_result already final
//  in_ready     out  1                  candidate accepted into S0 this edge
//  src_used     in   NUM_SRC            per-source "operand needed"
//  src_addr     in   NUM_SRC*REG_AW     source addresses of candidate
//  src_rf_data  in   NUM_SRC*DATA_W     register-file read data
//  src_data     out  NUM_SRC*DATA_W     forwarded-or-RF operand
//  fwd_hit      out  NUM_SRC            operand taken from a slot
//  upd_en       in   STAGES-1           stage s produced a result this cycle
//  upd_result   in   (STAGES-1)*DATA_W  result of stage s, captured into slot s+1
//  hold         in   1                  freeze all slots
//  flush        in   1                  invalidate young slots
//  slot_valid   out  STAGES             valid bit of every slot
//  slot_payload out  STAGES*PAYLOAD_W   payload of every slot (stage logic reads it)
//  out_valid/out_wb/out_dst/out_result out 1/1/REG_AW/DATA_W  oldest slot, to writeback
//  stall_req    out  1                  operand hazard on current candidate
//  bubble_cnt   out  16                 saturating count of stall bubbles
// BEHAVIOUR
//  - Reset: every slot valid=0, payload/result/dst=0, wb=0, res_rdy=0; bubble_cnt=0. Outputs derived from
//    slots therefore read 0. Rst has priority over every other input, including mid-stall/hold/flush.
//  - Forward search per source i (combinational): if src_used[i], scan S0..S[STAGES-1]; first slot with
//    valid&wb&dst==src_addr[i] is the match. Match with res_rdy=1 -> fwd_hit[i]=1, src_data=slot result.
//    Match with res_rdy=0 -> stall_req=1. No match / unused -> fwd_hit=0, src_data=src_rf_data[i].
//    Only the youngest match counts even if an older slot is ready. Invalid slots never match.
//  - in_ready = in_valid & ~hold & ~flush & ~stall_req (Rst forces 0).
//  - Edge priority: Rst > flush > hold > advance.
//  - Advance (no hold, no flush): S[s+1] <= S[s]; if upd_en[s], result<=upd_result[s] and res_rdy<=1, else
//    carried. S0 <= candidate when in_ready, else bubble (valid=0). Oldest slot leaves the chain.
//  - Hold (no flush): all slots unchanged, upd_en ignored, no acceptance, bubble_cnt unchanged.
//  - Flush: slots S0..S[FLUSH_N-1] valid<=0; if hold=0 the older slots still advance (S[FLUSH_N] gets a
//    bubble); if hold=1 older slots stay. Candidate not accepted.
//  - bubble_cnt increments (saturates at 16'hFFFF) on each advance edge where in_valid&stall_req.
//  - Latency: accepted candidate appears at out_* after STAGES advance edges; forwarding is zero-cycle.
//  - Widths: all data pass unchanged; no arithmetic except the saturating counter.
// TESTING
//  1 Rst high 2 cycles mid-traffic -> slot_valid=0, out_valid=0, bubble_cnt=0, in_ready=0 during Rst.
//  2 Issue R1<=5 (in_res_rdy=1), next cycle candidate src R1 -> fwd_hit[0]=1, src_data=5, no stall.
//  3 Load R2 (res_rdy=0), next candidate uses R2 -> stall_req=1, one bubble, bubble_cnt=1; after upd_en[0]
//    with 16'h00AB, candidate issues with src_data=16'h00AB.
//  4 R3<=1 in S2, R3<=7 in S0, both ready -> src R3 gives 7 (youngest wins).
//  5 flush with FLUSH_N=2, four valid slots -> S0,S1 invalid, old S2 moves to S3, S2 holds bubble.
//  6 hold 3 cycles with upd_en set -> slots and results unchanged, in_ready=0; release -> resumes in order.

Source files
------------

// File: rtl/pipe_hazard_chain.sv
// In-order pipeline backbone: STAGES slots with operand forwarding, load-use stall
// detection, bubble counting, global hold and partial flush of the young slots.
module pipe_hazard_chain #(
  parameter int STAGES    = 4,
  parameter int PAYLOAD_W = 64,
  parameter int DATA_W    = 16,
  parameter int REG_AW    = 3,
  parameter int NUM_SRC   = 2,
  parameter int FLUSH_N   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [PAYLOAD_W-1:0]          in_payload,
  input  logic                          in_wb,
  input  logic [REG_AW-1:0]             in_dst,
  input  logic [DATA_W-1:0]             in_result,
  input  logic                          in_res_rdy,
  output logic                          in_ready,
  input  logic [NUM_SRC-1:0]            src_used,
  input  logic [NUM_SRC*REG_AW-1:0]     src_addr,
  input  logic [NUM_SRC*DATA_W-1:0]     src_rf_data,
  output logic [NUM_SRC*DATA_W-1:0]     src_data,
  output logic [NUM_SRC-1:0]            fwd_hit,
  input  logic [STAGES-2:0]             upd_en,
  input  logic [(STAGES-1)*DATA_W-1:0]  upd_result,
  input  logic                          hold,
  input  logic                          flush,
  output logic [STAGES-1:0]             slot_valid,
  output logic [STAGES*PAYLOAD_W-1:0]   slot_payload,
  output logic                          out_valid,
  output logic                          out_wb,
  output logic [REG_AW-1:0]             out_dst,
  output logic [DATA_W-1:0]             out_result,
  output logic                          stall_req,
  output logic [15:0]                   bubble_cnt
);

  logic                        slot_vld [STAGES];
  logic                        slot_wb  [STAGES];
  logic                        slot_rdy [STAGES];
  logic [REG_AW-1:0]           slot_dst [STAGES];
  logic signed [DATA_W-1:0]    slot_res [STAGES];
  logic [PAYLOAD_W-1:0]        slot_pay [STAGES];

  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    return (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Forward search: the youngest matching slot decides, ready or not.
  always_comb begin
    logic found;
    found     = 1'b0;
    src_data  = src_rf_data;
    fwd_hit   = '0;
    stall_req = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      found = 1'b0;
      for (int s = 0; s < STAGES; s++) begin
        if (src_used[i] && !found && slot_vld[s] && slot_wb[s] &&
            slot_dst[s] == src_addr[i*REG_AW +: REG_AW]) begin
          found = 1'b1;
          if (slot_rdy[s]) begin
            fwd_hit[i]                    = 1'b1;
            src_data[i*DATA_W +: DATA_W]  = slot_res[s];
          end else begin
            stall_req = 1'b1;
          end
        end
      end
    end
  end

  assign in_ready = in_valid & ~hold & ~flush & ~stall_req & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        slot_vld[s] <= 1'b0;
        slot_wb[s]  <= 1'b0;
        slot_rdy[s] <= 1'b0;
        slot_dst[s] <= '0;
        slot_res[s] <= '0;
        slot_pay[s] <= '0;
      end
      bubble_cnt <= 16'd0;
    end else if (!hold) begin
      // Advance: slots flushed this edge move on as bubbles.
      for (int s = 1; s < STAGES; s++) begin
        slot_vld[s] <= slot_vld[s-1] && !(flush && (s - 1) < FLUSH_N);
        slot_wb[s]  <= slot_wb[s-1];
        slot_dst[s] <= slot_dst[s-1];
        slot_pay[s] <= slot_pay[s-1];
        if (upd_en[s-1]) begin
          slot_res[s] <= upd_result[(s-1)*DATA_W +: DATA_W];
          slot_rdy[s] <= 1'b1;
        end else begin
          slot_res[s] <= slot_res[s-1];
          slot_rdy[s] <= slot_rdy[s-1];
        end
      end
      slot_vld[0] <= in_ready;
      slot_wb[0]  <= in_wb;
      slot_dst[0] <= in_dst;
      slot_res[0] <= in_result;
      slot_rdy[0] <= in_res_rdy;
      slot_pay[0] <= in_payload;
      if (!flush && in_valid && stall_req)
        bubble_cnt <= sat_inc(bubble_cnt);
    end else if (flush) begin
      for (int s = 0; s < FLUSH_N; s++)
        slot_vld[s] <= 1'b0;
    end
  end

  always_comb begin
    slot_valid   = '0;
    slot_payload = '0;
    for (int s = 0; s < STAGES; s++) begin
      slot_valid[s]                         = slot_vld[s];
      slot_payload[s*PAYLOAD_W +: PAYLOAD_W] = slot_pay[s];
    end
  end

  assign out_valid  = slot_vld[STAGES-1];
  assign out_wb     = slot_wb[STAGES-1];
  assign out_dst    = slot_dst[STAGES-1];
  assign out_result = slot_res[STAGES-1];

endmodule

// File: tb/tb_pipe_hazard_chain.sv
// Bench for pipe_hazard_chain: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_hazard_chain;
  localparam int ST = 4;
  localparam int PW = 64;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NS = 2;
  localparam int FN = 2;

  logic clk = 1'b0;
  logic rst, in_valid, in_wb, in_res_rdy, in_ready, hold, flush;
  logic [PW-1:0] in_payload;
  logic [AW-1:0] in_dst;
  logic [DW-1:0] in_result;
  logic [NS-1:0] src_used, fwd_hit;
  logic [NS*AW-1:0] src_addr;
  logic [NS*DW-1:0] src_rf_data, src_data;
  logic [ST-2:0] upd_en;
  logic [(ST-1)*DW-1:0] upd_result;
  logic [ST-1:0] slot_valid;
  logic [ST*PW-1:0] slot_payload;
  logic out_valid, out_wb, stall_req;
  logic [AW-1:0] out_dst;
  logic [DW-1:0] out_result;
  logic [15:0] bubble_cnt;

  pipe_hazard_chain #(.STAGES(ST), .PAYLOAD_W(PW), .DATA_W(DW), .REG_AW(AW),
                      .NUM_SRC(NS), .FLUSH_N(FN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_payload(in_payload), .in_wb(in_wb),
    .in_dst(in_dst), .in_result(in_result), .in_res_rdy(in_res_rdy), .in_ready(in_ready),
    .src_used(src_used), .src_addr(src_addr), .src_rf_data(src_rf_data),
    .src_data(src_data), .fwd_hit(fwd_hit), .upd_en(upd_en), .upd_result(upd_result),
    .hold(hold), .flush(flush), .slot_valid(slot_valid), .slot_payload(slot_payload),
    .out_valid(out_valid), .out_wb(out_wb), .out_dst(out_dst), .out_result(out_result),
    .stall_req(stall_req), .bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    bit          wb;
    bit          rdy;
    logic [AW-1:0] dst;
    logic [DW-1:0] res;
    logic [PW-1:0] pl;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mcnt = 16'd0;
  int          total = 0;
  int          bad = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Instruction list, youngest first: who does each source operand come from?
  task automatic mcomb(output logic st, output logic [NS-1:0] hit, output logic [NS*DW-1:0] dat);
    st  = 1'b0;
    hit = '0;
    dat = src_rf_data;
    for (int i = 0; i < NS; i++) begin
      if (src_used[i]) begin
        for (int k = 0; k < ST; k++) begin
          if (mq[k].v && mq[k].wb && mq[k].dst == src_addr[i*AW +: AW]) begin
            if (mq[k].rdy) begin
              hit[i] = 1'b1;
              dat[i*DW +: DW] = mq[k].res;
            end else begin
              st = 1'b1;
            end
            break;
          end
        end
      end
    end
  endtask

  initial begin
    ent_t z;
    z = '{v: 0, wb: 0, rdy: 0, dst: '0, res: '0, pl: '0};
    repeat (ST) mq.push_back(z);
  end

  always @(posedge clk) begin
    ent_t e;
    ent_t z;
    logic st;
    logic [NS-1:0] h;
    logic [NS*DW-1:0] d;
    z = '{v: 0, wb: 0, rdy: 0, dst: '0, res: '0, pl: '0};
    if (rst) begin
      mq.delete();
      repeat (ST) mq.push_back(z);
      mcnt = 16'd0;
    end else begin
      mcomb(st, h, d);
      if (!hold) begin
        for (int k = 0; k < ST - 1; k++) begin
          if (upd_en[k]) begin
            e = mq[k];
            e.res = upd_result[k*DW +: DW];
            e.rdy = 1'b1;
            mq[k] = e;
          end
        end
      end
      if (flush) begin
        for (int k = 0; k < FN; k++) begin
          e = mq[k];
          e.v = 1'b0;
          mq[k] = e;
        end
      end
      if (!hold) begin
        e = '{v: in_valid && !flush && !st, wb: in_wb, rdy: in_res_rdy,
              dst: in_dst, res: in_result, pl: in_payload};
        mq.push_front(e);
        void'(mq.pop_back());
        if (!flush && in_valid && st && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
      end
    end
  end

  always @(negedge clk) begin
    logic st;
    logic [NS-1:0] h;
    logic [NS*DW-1:0] d;
    if (chk_en) begin
      mcomb(st, h, d);
      chk("stall_req", {63'd0, stall_req}, {63'd0, st});
      chk("fwd_hit", {62'd0, fwd_hit}, {62'd0, h});
      chk("src_data", {32'd0, src_data}, {32'd0, d});
      chk("in_ready", {63'd0, in_ready}, {63'd0, in_valid & ~hold & ~flush & ~st & ~rst});
      for (int k = 0; k < ST; k++) begin
        chk("slot_valid", {63'd0, slot_valid[k]}, {63'd0, mq[k].v});
        if (mq[k].v) chk("slot_payload", slot_payload[k*PW +: PW], mq[k].pl);
      end
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq[ST-1].v});
      if (mq[ST-1].v) begin
        chk("out_wb", {63'd0, out_wb}, {63'd0, mq[ST-1].wb});
        chk("out_dst", {61'd0, out_dst}, {61'd0, mq[ST-1].dst});
        chk("out_result", {48'd0, out_result}, {48'd0, mq[ST-1].res});
      end
      chk("bubble_cnt", {48'd0, bubble_cnt}, {48'd0, mcnt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; in_valid = 0; in_payload = '0; in_wb = 0; in_dst = '0; in_result = '0;
    in_res_rdy = 0; src_used = '0; src_addr = '0; src_rf_data = '0; upd_en = '0;
    upd_result = '0; hold = 0; flush = 0;
  endtask

  task automatic rnd();
    rst         = ($urandom_range(0, 199) == 0);
    in_valid    = ($urandom_range(0, 3) != 0);
    in_payload  = {$urandom, $urandom};
    in_wb       = $urandom_range(0, 1);
    in_dst      = AW'($urandom_range(0, 3));
    in_result   = DW'($urandom);
    in_res_rdy  = $urandom_range(0, 1);
    src_used    = NS'($urandom);
    src_addr    = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
    src_rf_data = {DW'($urandom), DW'($urandom)};
    upd_en      = (ST-1)'($urandom);
    upd_result  = {DW'($urandom), DW'($urandom), DW'($urandom)};
    hold        = ($urandom_range(0, 7) == 0);
    flush       = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    idle();
    // Reset with traffic on the inputs
    rst = 1; in_valid = 1; in_wb = 1; in_dst = 3'd1; in_res_rdy = 1;
    @(negedge clk); chk("rst_in_ready0", {63'd0, in_ready}, 64'd0);
    tick();
    @(negedge clk); chk("rst_in_ready1", {63'd0, in_ready}, 64'd0);
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_slot_valid", {60'd0, slot_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_bubble", {48'd0, bubble_cnt}, 64'd0);
    chk("rst_out_result", {48'd0, out_result}, 64'd0);
    chk("rst_out_dst", {61'd0, out_dst}, 64'd0);
    tick();
    idle();

    // R1 <= 5 ready, then a consumer of R1
    in_valid = 1; in_wb = 1; in_dst = 3'd1; in_result = 16'd5; in_res_rdy = 1; in_payload = 64'h100;
    @(negedge clk); chk("r1_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_wb = 0; in_payload = 64'h101; src_used = 2'b01; src_addr = {3'd0, 3'd1};
    src_rf_data = {16'h2222, 16'h1111};
    @(negedge clk);
    chk("fwd_r1_hit", {63'd0, fwd_hit[0]}, 64'd1);
    chk("fwd_r1_data", {48'd0, src_data[15:0]}, 64'd5);
    chk("fwd_r1_stall", {63'd0, stall_req}, 64'd0);
    tick();

    // Load R2 not ready, consumer stalls one bubble
    src_used = 2'b00; in_wb = 1; in_dst = 3'd2; in_res_rdy = 0; in_result = '0; in_payload = 64'h102;
    @(negedge clk); chk("ld_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_wb = 0; src_used = 2'b01; src_addr = {3'd0, 3'd2}; upd_en = 3'b001;
    upd_result = {16'h0, 16'h0, 16'h00AB}; in_payload = 64'h103;
    @(negedge clk);
    chk("lu_stall", {63'd0, stall_req}, 64'd1);
    chk("lu_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    upd_en = '0;
    @(negedge clk);
    chk("lu_stall_clr", {63'd0, stall_req}, 64'd0);
    chk("lu_fwd_hit", {63'd0, fwd_hit[0]}, 64'd1);
    chk("lu_fwd_data", {48'd0, src_data[15:0]}, 64'h00AB);
    chk("lu_bubble_cnt", {48'd0, bubble_cnt}, 64'd1);
    chk("lu_issue", {63'd0, in_ready}, 64'd1);
    tick();

    // R3 <= 1 older, R3 <= 7 younger: youngest wins
    src_used = 2'b00; in_wb = 1; in_dst = 3'd3; in_result = 16'd1; in_res_rdy = 1; in_payload = 64'h104;
    tick();
    in_valid = 0;
    tick();
    in_valid = 1; in_result = 16'd7; in_payload = 64'h105;
    tick();
    in_valid = 0; src_used = 2'b01; src_addr = {3'd0, 3'd3};
    @(negedge clk);
    chk("young_hit", {63'd0, fwd_hit[0]}, 64'd1);
    chk("young_data", {48'd0, src_data[15:0]}, 64'd7);
    tick();

    // Fill four slots, then flush the two young ones
    src_used = 2'b00; in_valid = 1; in_wb = 0;
    for (int k = 0; k < 4; k++) begin
      in_payload = 64'hA1 + 64'(k);
      tick();
    end
    flush = 1;
    @(negedge clk);
    chk("pre_flush_valid", {60'd0, slot_valid}, 64'hF);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
    tick();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_valid", {60'd0, slot_valid}, 64'h8);
    chk("flush_s3_payload", slot_payload[3*PW +: PW], 64'hA2);
    tick();

    // Refill, then hold three cycles with updates pending
    in_valid = 1; in_wb = 1; in_dst = 3'd5; in_res_rdy = 1; in_result = 16'h0011; in_payload = 64'hB1;
    tick();
    in_wb = 0;
    for (int k = 2; k <= 4; k++) begin
      in_payload = 64'hB0 + 64'(k);
      tick();
    end
    hold = 1; upd_en = 3'b111; upd_result = {16'h0DEF, 16'h0CDE, 16'h0BCD}; in_payload = 64'hC0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_valid", {60'd0, slot_valid}, 64'hF);
      chk("hold_s0", slot_payload[0 +: PW], 64'hB4);
      chk("hold_s3", slot_payload[3*PW +: PW], 64'hB1);
      chk("hold_result", {48'd0, out_result}, 64'h0011);
      tick();
    end
    hold = 0; upd_en = '0; in_valid = 0;
    tick();
    @(negedge clk);
    chk("release_valid", {60'd0, slot_valid}, 64'hE);
    chk("release_s3", slot_payload[3*PW +: PW], 64'hB2);
    tick();

    // Reset in the middle of random traffic
    for (int c = 0; c < 20; c++) begin
      rnd();
      rst = 0;
      tick();
    end
    rst = 1; in_valid = 1;
    @(negedge clk); chk("mid_rst_in_ready0", {63'd0, in_ready}, 64'd0);
    tick();
    @(negedge clk); chk("mid_rst_in_ready1", {63'd0, in_ready}, 64'd0);
    tick();
    idle();
    @(negedge clk);
    chk("mid_rst_valid", {60'd0, slot_valid}, 64'd0);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_bubble", {48'd0, bubble_cnt}, 64'd0);
    tick();

    for (int c = 0; c < 3000; c++) begin
      rnd();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
